// File: rtl/hog_ext_bus_ctrl.sv
// HOG descriptor FIFO plus bus-slave register block with a four-state handshake.
// Define HOG_BUS_STATS_EN to add the pop / frame-end counters at addresses 5 and 6.
module hog_ext_bus_ctrl #(
    parameter int BUS_WIDTH  = 128,
    parameter int ADDR_WIDTH = 5,
    parameter int FIFO_DEPTH = 64
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [BUS_WIDTH-1:0]   desc_data,
    input  logic                   desc_valid,
    output logic                   desc_ready,
    input  logic [ADDR_WIDTH-1:0]  addr,
    input  logic                   bus_enable,
    input  logic                   r_wbar,
    input  logic [BUS_WIDTH-1:0]   write_data,
    input  logic [BUS_WIDTH/8-1:0] byte_enable,
    output logic [BUS_WIDTH-1:0]   read_data,
    output logic                   ack,
    output logic                   irq,
    output logic                   hog_enable
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int LVL_W = PTR_W + 1;

    localparam logic [ADDR_WIDTH-1:0] A_DATA    = ADDR_WIDTH'(0);
    localparam logic [ADDR_WIDTH-1:0] A_STATUS  = ADDR_WIDTH'(1);
    localparam logic [ADDR_WIDTH-1:0] A_CONTROL = ADDR_WIDTH'(2);
    localparam logic [ADDR_WIDTH-1:0] A_THRESH  = ADDR_WIDTH'(3);
    localparam logic [ADDR_WIDTH-1:0] A_IRQ_CLR = ADDR_WIDTH'(4);
`ifdef HOG_BUS_STATS_EN
    localparam logic [ADDR_WIDTH-1:0] A_POPS    = ADDR_WIDTH'(5);
    localparam logic [ADDR_WIDTH-1:0] A_FES     = ADDR_WIDTH'(6);
`endif

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCESS,
        S_ACK,
        S_WAIT_REL
    } state_t;

    state_t state, state_nxt;

    logic [BUS_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]     wr_ptr, rd_ptr;
    logic [LVL_W-1:0]     level;
    logic                 fifo_empty, fifo_full, push, pop;
    logic                 underflow, irq_pending, hog_en_q, irq_en_q;
    logic [15:0]          threshold;
    logic [31:0]          wmask, wdata_m;
    logic                 acc_rd, acc_wr, irq_set, irq_clr;
    logic [BUS_WIDTH-1:0] rd_val;
    logic                 unused_bits;

    assign unused_bits = ^{write_data[BUS_WIDTH-1:32], byte_enable[BUS_WIDTH/8-1:4]};

    assign fifo_empty = (level == '0);
    assign fifo_full  = (level == LVL_W'(FIFO_DEPTH));
    // Full is judged on the registered level, so a push never lands on a full FIFO.
    assign desc_ready = !rst && !fifo_full;
    assign push       = desc_valid && desc_ready;

    assign acc_rd = (state == S_ACCESS) && r_wbar;
    assign acc_wr = (state == S_ACCESS) && !r_wbar;
    assign pop    = acc_rd && (addr == A_DATA) && !fifo_empty;

    assign wmask   = {{8{byte_enable[3]}}, {8{byte_enable[2]}},
                      {8{byte_enable[1]}}, {8{byte_enable[0]}}};
    assign wdata_m = write_data[31:0] & wmask;

    assign irq_set = ((threshold != 16'd0) && (32'(level) >= 32'(threshold)))
                   || (push && desc_data[BUS_WIDTH-1]);
    assign irq_clr = acc_wr && (addr == A_IRQ_CLR) && wdata_m[0];

    assign irq        = irq_pending && irq_en_q;
    assign hog_enable = hog_en_q;

`ifdef HOG_BUS_STATS_EN
    logic [31:0] pop_count, fe_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            pop_count <= '0;
            fe_count  <= '0;
        end else begin
            if (acc_wr && (addr == A_POPS))
                pop_count <= '0;
            else if (pop)
                pop_count <= pop_count + 32'd1;
            if (acc_wr && (addr == A_FES))
                fe_count <= '0;
            else if (push && desc_data[BUS_WIDTH-1])
                fe_count <= fe_count + 32'd1;
        end
    end
`endif

    always_comb begin
        state_nxt = state;
        ack       = 1'b0;
        case (state)
            S_IDLE:     if (bus_enable) state_nxt = S_ACCESS;
            S_ACCESS:   state_nxt = S_ACK;
            S_ACK: begin
                ack       = 1'b1;
                state_nxt = S_WAIT_REL;
            end
            S_WAIT_REL: if (!bus_enable) state_nxt = S_IDLE;
            default:    state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        rd_val = '0;
        case (addr)
            A_DATA:    if (!fifo_empty) rd_val = mem[rd_ptr];
            A_STATUS:  rd_val[19:0] = {irq_pending, underflow, fifo_full, fifo_empty, 16'(level)};
            A_CONTROL: rd_val[1:0]  = {irq_en_q, hog_en_q};
            A_THRESH:  rd_val[15:0] = threshold;
`ifdef HOG_BUS_STATS_EN
            A_POPS:    rd_val[31:0] = pop_count;
            A_FES:     rd_val[31:0] = fe_count;
`endif
            default:   rd_val = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= desc_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            level       <= '0;
            read_data   <= '0;
            underflow   <= 1'b0;
            irq_pending <= 1'b0;
            hog_en_q    <= 1'b0;
            irq_en_q    <= 1'b0;
            threshold   <= '0;
        end else begin
            state <= state_nxt;
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
            if (acc_rd) read_data <= rd_val;
            if (acc_rd && (addr == A_DATA) && fifo_empty)
                underflow <= 1'b1;
            else if (acc_wr && (addr == A_IRQ_CLR) && wdata_m[18])
                underflow <= 1'b0;
            // A set condition in the same cycle as a clear keeps the interrupt pending.
            if (irq_set)
                irq_pending <= 1'b1;
            else if (irq_clr)
                irq_pending <= 1'b0;
            if (acc_wr && (addr == A_CONTROL) && byte_enable[0]) begin
                hog_en_q <= write_data[0];
                irq_en_q <= write_data[1];
            end
            if (acc_wr && (addr == A_THRESH))
                threshold <= (threshold & ~wmask[15:0]) | wdata_m[15:0];
        end
    end

endmodule

// File: tb/tb_hog_ext_bus_ctrl.sv
// Self-checking bench for hog_ext_bus_ctrl: directed scenarios plus a randomized phase,
// compared every cycle against a queue-based behavioural model of the register block.
module tb_hog_ext_bus_ctrl;

  localparam int BW    = 128;
  localparam int AW    = 5;
  localparam int DEPTH = 64;
`ifdef HOG_BUS_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [BW-1:0]   desc_data = '0;
  logic            desc_valid = 1'b0;
  logic            desc_ready;
  logic [AW-1:0]   addr = '0;
  logic            bus_enable = 1'b0;
  logic            r_wbar = 1'b1;
  logic [BW-1:0]   write_data = '0;
  logic [BW/8-1:0] byte_enable = '0;
  logic [BW-1:0]   read_data;
  logic            ack, irq, hog_enable;

  hog_ext_bus_ctrl #(.BUS_WIDTH(BW), .ADDR_WIDTH(AW), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .desc_data(desc_data), .desc_valid(desc_valid), .desc_ready(desc_ready),
    .addr(addr), .bus_enable(bus_enable), .r_wbar(r_wbar),
    .write_data(write_data), .byte_enable(byte_enable),
    .read_data(read_data), .ack(ack), .irq(irq), .hog_enable(hog_enable)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [BW-1:0] got, input logic [BW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference model. Bus handshake rules: an access happens one edge after
  // bus_enable is first sampled high, ack is visible for the following cycle,
  // and a new request is only taken after bus_enable has been seen low once
  // the ack cycle is over.
  logic [BW-1:0] exp_q[$];
  int            m_cyc = 0;
  int            m_acc = -1;
  bit            m_armed = 1'b1;
  bit            m_ack = 1'b0;
  logic [BW-1:0] m_rd = '0;
  bit            m_pend = 1'b0, m_und = 1'b0, m_hog = 1'b0, m_ien = 1'b0;
  int unsigned   m_thr = 0, m_popc = 0, m_fec = 0;

  always @(posedge clk) begin
    int unsigned lvl;
    bit          pushing, set_c, clr_c;
    logic [31:0] mask, wd;
    m_cyc++;
    m_ack = 1'b0;
    if (rst) begin
      exp_q.delete();
      m_acc = -1; m_armed = 1'b1; m_rd = '0;
      m_pend = 1'b0; m_und = 1'b0; m_hog = 1'b0; m_ien = 1'b0;
      m_thr = 0; m_popc = 0; m_fec = 0;
    end else begin
      lvl     = exp_q.size();
      pushing = desc_valid && (lvl < DEPTH);
      set_c   = ((m_thr != 0) && (lvl >= m_thr)) || (pushing && desc_data[BW-1]);
      clr_c   = 1'b0;
      if (m_acc == m_cyc) begin
        m_ack = 1'b1;
        if (r_wbar) begin
          m_rd = '0;
          case (int'(addr))
            0: if (lvl > 0) begin m_rd = exp_q.pop_front(); m_popc++; end
               else m_und = 1'b1;
            1: begin
                 m_rd[15:0] = lvl[15:0];
                 m_rd[16] = (lvl == 0);
                 m_rd[17] = (lvl == DEPTH);
                 m_rd[18] = m_und;
                 m_rd[19] = m_pend;
               end
            2: m_rd[1:0] = {m_ien, m_hog};
            3: m_rd[15:0] = m_thr[15:0];
            5: if (STATS) m_rd[31:0] = m_popc;
            6: if (STATS) m_rd[31:0] = m_fec;
            default: m_rd = '0;
          endcase
        end else begin
          for (int b = 0; b < 4; b++) mask[b*8 +: 8] = {8{byte_enable[b]}};
          wd = write_data[31:0] & mask;
          case (int'(addr))
            2: if (byte_enable[0]) begin m_hog = wd[0]; m_ien = wd[1]; end
            3: m_thr = (m_thr & ~{16'h0, mask[15:0]}) | {16'h0, wd[15:0]};
            4: begin if (wd[0]) clr_c = 1'b1; if (wd[18]) m_und = 1'b0; end
            5: m_popc = 0;
            6: m_fec = 0;
            default: ;
          endcase
        end
      end else if ((m_acc < m_cyc) && m_armed && bus_enable) begin
        m_acc = m_cyc + 1;
        m_armed = 1'b0;
      end else if (!m_armed && (m_cyc > m_acc + 1) && !bus_enable) begin
        m_armed = 1'b1;
      end
      if (pushing) begin
        exp_q.push_back(desc_data);
        if (desc_data[BW-1]) m_fec++;
      end
      m_pend = set_c ? 1'b1 : (clr_c ? 1'b0 : m_pend);
    end
  end

  // Output monitor, sampled mid-way through the low clock phase.
  always begin
    @(negedge clk);
    #2;
    check("desc_ready", desc_ready, !rst && (exp_q.size() < DEPTH));
    check("ack", ack, m_ack);
    check("irq", irq, m_pend && m_ien);
    check("hog_enable", hog_enable, m_hog);
    check("read_data", read_data, m_rd);
  end

  // driver tasks
  bit rand_desc = 1'b0;

  function automatic logic [BW-1:0] rand_word();
    logic [BW-1:0] w;
    for (int i = 0; i < BW/32; i++) w[i*32 +: 32] = $urandom;
    return w;
  endfunction

  function automatic logic [BW-1:0] mk_word(input logic [2:0] meta, input logic [7:0] tag);
    logic [BW-1:0] w;
    w = rand_word();
    w[BW-1 -: 3] = meta;
    w[7:0] = tag;
    return w;
  endfunction

  task automatic tick();
    @(negedge clk);
    if (rand_desc) begin
      desc_valid = ($urandom_range(0, 2) != 0);
      desc_data  = rand_word();
    end
  endtask

  task automatic bus_op(input int a, input logic rw, input logic [31:0] wd,
                        input logic [15:0] be, output logic [BW-1:0] rd);
    bit got;
    got = 1'b0;
    tick();
    addr = AW'(a); r_wbar = rw; byte_enable = be;
    write_data = rand_word();
    write_data[31:0] = wd;
    bus_enable = 1'b1;
    for (int i = 0; i < 10 && !got; i++) begin
      tick();
      if (ack) got = 1'b1;
    end
    if (!got) check("ack_timeout", 1'b0, 1'b1);
    rd = read_data;
    bus_enable = 1'b0;
    tick();
    tick();
  endtask

  task automatic bus_rd(input int a, output logic [BW-1:0] rd);
    bus_op(a, 1'b1, 32'h0, 16'h0, rd);
  endtask

  task automatic bus_wr(input int a, input logic [31:0] wd);
    logic [BW-1:0] rd;
    bus_op(a, 1'b0, wd, 16'hFFFF, rd);
  endtask

  task automatic push_word(input logic [BW-1:0] d);
    int n;
    tick();
    desc_valid = 1'b1;
    desc_data  = d;
    n = 0;
    while (!desc_ready && n < 200) begin tick(); n++; end
    if (n >= 200) check("push_timeout", 1'b0, 1'b1);
    tick();
    desc_valid = 1'b0;
  endtask

  logic [BW-1:0] rd;

  initial begin
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // reset state
    bus_rd(1, rd);
    check("status_after_reset", rd[31:0], 32'h0001_0000);

    // FIFO order and underflow
    push_word(mk_word(3'b000, 8'hA1));
    push_word(mk_word(3'b000, 8'hA2));
    push_word(mk_word(3'b000, 8'hA3));
    bus_rd(0, rd); check("pop_a1", rd[7:0], 8'hA1);
    bus_rd(0, rd); check("pop_a2", rd[7:0], 8'hA2);
    bus_rd(0, rd); check("pop_a3", rd[7:0], 8'hA3);
    bus_rd(0, rd); check("pop_empty", rd, '0);
    bus_rd(1, rd); check("underflow_sticky", rd[18], 1'b1);
    bus_wr(4, 32'h0004_0000);
    bus_rd(1, rd); check("underflow_cleared", rd[18], 1'b0);

    // threshold interrupt
    bus_wr(3, 32'd4);
    bus_wr(2, 32'h3);
    for (int i = 0; i < 4; i++) push_word(mk_word(3'b000, 8'(i)));
    check("irq_before_set", irq, 1'b0);
    tick();
    check("irq_after_set", irq, 1'b1);
    bus_wr(4, 32'h1);
    check("irq_clear_blocked", irq, 1'b1);
    bus_rd(0, rd);
    bus_wr(4, 32'h1);
    check("irq_cleared", irq, 1'b0);

    // full FIFO and pop with a waiting push
    for (int i = 0; i < DEPTH - 3; i++) push_word(mk_word(3'b000, 8'(i)));
    check("full_not_ready", desc_ready, 1'b0);
    bus_rd(1, rd);
    check("status_full", rd[17], 1'b1);
    check("status_level_full", rd[15:0], 16'd64);
    desc_data = mk_word(3'b000, 8'h5A);
    desc_valid = 1'b1;
    bus_rd(0, rd);
    tick();
    desc_valid = 1'b0;
    bus_rd(1, rd);
    check("level_after_pop_push", rd[15:0], 16'd64);
    for (int i = 0; i < DEPTH; i++) bus_rd(0, rd);

    // frame-end interrupt and byte enables
    bus_wr(3, 32'h0);
    bus_wr(4, 32'h1);
    push_word(mk_word(3'b100, 8'hFE));
    tick();
    bus_rd(1, rd);
    check("frame_end_pending", rd[19], 1'b1);
    check("frame_end_irq", irq, 1'b1);
    bus_op(2, 1'b0, 32'h0, 16'h0, rd);
    check("ctrl_be_zero", hog_enable, 1'b1);

    // statistics counters
    bus_wr(5, 32'hDEAD);
    bus_wr(6, 32'hBEEF);
    for (int i = 0; i < 5; i++) push_word(mk_word((i < 2) ? 3'b100 : 3'b000, 8'(i)));
    for (int i = 0; i < 5; i++) bus_rd(0, rd);
    bus_rd(5, rd); check("stat_pops", rd[31:0], STATS ? 32'd5 : 32'd0);
    bus_rd(6, rd); check("stat_frame_ends", rd[31:0], STATS ? 32'd2 : 32'd0);

    // reset in the middle of a read; the held request restarts afterwards
    push_word(mk_word(3'b000, 8'h11));
    tick();
    addr = AW'(0); r_wbar = 1'b1; bus_enable = 1'b1;
    tick();
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    begin
      bit got;
      got = 1'b0;
      for (int i = 0; i < 10 && !got; i++) begin
        tick();
        if (ack) got = 1'b1;
      end
      check("ack_after_reset", got, 1'b1);
      check("read_after_flush", read_data, '0);
      bus_enable = 1'b0;
      tick(); tick();
    end

    // randomized traffic
    bus_wr(2, 32'h3);
    rand_desc = 1'b1;
    for (int i = 0; i < 400; i++) begin
      int a;
      logic rw;
      logic [31:0] wd;
      a  = $urandom_range(0, 7);
      rw = ($urandom_range(0, 3) != 0);
      wd = (a == 3) ? $urandom_range(0, 70) : $urandom;
      bus_op(a, rw, wd, 16'($urandom), rd);
    end
    rand_desc = 1'b0;
    desc_valid = 1'b0;
    repeat (4) tick();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
